// File: rtl/multi_cycle_mul.sv
// Iterative radix-2 shift-add unsigned multiplier for the UMUL op.
// Takes WIDTH RUN cycles per product and holds the front end via stall while a request is in flight.
module multi_cycle_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH:0]   add_sum;

    // Partial-product add on the upper half; the carry becomes the new MSB after the shift.
    always_comb begin
        add_sum = {1'b0, prod_q[PW-1:WIDTH]};
        if (prod_q[0]) begin
            add_sum = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, mcand_q};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = src_a;
                    prod_d  = {{WIDTH{1'b0}}, src_b};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                prod_d = {add_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result_lo = prod_q[WIDTH-1:0];
    assign result_hi = prod_q[PW-1:WIDTH];
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    // Stall drops in DONE so the Controller retires the op that cycle.
    assign stall     = ((state_q == S_IDLE) && start) || (state_q == S_RUN);

endmodule

// File: tb/tb_multi_cycle_mul.sv
// Scoreboard bench for multi_cycle_mul: expected products are queued at accept
// and compared, along with latency, whenever done is seen.
module tb_multi_cycle_mul;

    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [63:0] prod;
        int          acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] src_a = '0;
    logic [WIDTH-1:0] src_b = '0;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             busy;
    logic             done;
    logic             stall;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;
    exp_t exp_q[$];

    multi_cycle_mul #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_a     (src_a),
        .src_b     (src_b),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every done must match the oldest queued product and latency.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check_eq("done_width", 64'(prev_done), 64'd0);
            check_eq("stall_done", 64'(stall), 64'd0);
            check_eq("busy_done", 64'(busy), 64'd0);
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 64'(done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("result", {result_hi, result_lo}, e.prod);
                check_eq("latency", 64'(cyc - e.acc), 64'(WIDTH));
            end
        end
        prev_done = done;
    end

    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int acc);
        exp_t e;
        e.prod = 64'(a) * 64'(b);
        e.acc  = acc;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        src_a = a;
        src_b = b;
        start = 1'b1;
        push_exp(a, b, cyc + 1);
        #1 check_eq("stall_accept", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        #1;
        check_eq("busy_run", 64'(busy), 64'd1);
        check_eq("stall_run", 64'(stall), 64'd1);
        wait_drain(3 * WIDTH);
    endtask

    initial begin
        int n;
        // Reset state
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_result", {result_hi, result_lo}, 64'd0);
        rst = 1'b0;

        // Directed products, including all-ones and zero operands
        run_op(32'd3, 32'd5);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'h0001_0000, 32'h0001_0000);
        run_op(32'd0, 32'd7);
        run_op(32'd1, 32'hFFFF_FFFF);

        // Noisy start/operands during RUN/DONE, then start held into IDLE
        @(negedge clk);
        src_a = 32'd6;
        src_b = 32'd7;
        start = 1'b1;
        push_exp(32'd6, 32'd7, cyc + 1);
        #1 check_eq("stall_accept2", 64'(stall), 64'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 3 * WIDTH) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            src_a = $urandom;
            src_b = $urandom;
            #1;
            n++;
        end
        check_eq("drain_noisy", 64'(exp_q.size()), 64'd0);
        start = 1'b1;
        src_a = 32'd11;
        src_b = 32'd13;
        push_exp(32'd11, 32'd13, cyc + 2);
        @(negedge clk);
        #1;
        check_eq("b2b_idle_stall", 64'(stall), 64'd1);
        check_eq("b2b_idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1 check_eq("b2b_busy", 64'(busy), 64'd1);
        wait_drain(3 * WIDTH);

        // Reset in the middle of RUN discards the operation
        @(negedge clk);
        src_a = 32'd9;
        src_b = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_stall", 64'(stall), 64'd0);
        check_eq("abort_result", {result_hi, result_lo}, 64'd0);
        rst = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);
        run_op(32'd2, 32'd2);

        // Random products with idle gaps
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($urandom, $urandom);
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
